fir_decimate: RTL
=================

// Module: fir_decimate
// PURPOSE
//   Decimating FIR engine that drives the dual-port coefficient ROM upstream of it.
//   Stores input samples in a circular buffer and computes one output per DECIMATE inputs.
//   Each computation reads two taps per cycle (ROM port 1 = even tap, port 2 = odd tap)
//   and accumulates them into a multiply-accumulate (MAC) sum.
//   The result is rounded and saturated, then handed to the downstream stage as a one-cycle valid pulse.
// PARAMETERS
//   N_TAPS        120  filter length; must be even and <= 2**ADDRESS_WIDTH
//   DECIMATE      20   input samples per output sample
//   IN_WIDTH      12   signed input sample width
//   COEFF_WIDTH   16   signed coefficient width (ROM DATA_WIDTH)
//   ADDRESS_WIDTH 7    ROM address width
//   OUT_WIDTH     16   signed output width
//   OUT_SHIFT     8    accumulator LSBs discarded before saturation; must be >= 1
// PORTS
//   clk        in   1              system clock
//   rst_n      in   1              asynchronous, active-low reset
//   din_valid  in   1              din carries a new sample this cycle
//   din        in   IN_WIDTH       signed input sample
//   rom_en1    out  1              ROM port 1 enable
//   rom_en2    out  1              ROM port 2 enable
//   rom_addr1  out  ADDRESS_WIDTH  even tap address
//   rom_addr2  out  ADDRESS_WIDTH  odd tap address
//   rom_do1    in   COEFF_WIDTH    ROM port 1 data; 1-cycle read latency
//   rom_do2    in   COEFF_WIDTH    ROM port 2 data; 1-cycle read latency
//   dout_valid out  1              one-cycle pulse, dout valid
//   dout       out  OUT_WIDTH      signed filtered, decimated sample
//   busy       out  1              computation in progress
//   overrun    out  1              one-cycle pulse: trigger dropped
// BEHAVIOUR
//   Reset: all outputs are 0, the sample buffer is cleared to 0, the write pointer and
//     decimation count are 0, and the FSM goes to IDLE. Reset asserted mid-computation
//     abandons that computation; no dout_valid is produced for it.
//   Buffer: depth N_TAPS+DECIMATE registers, written on every din_valid (also while busy).
//     The write pointer wraps modulo the depth. The extra DECIMATE entries keep samples
//     written during a computation from clobbering taps that are still in use.
//   Trigger: a din_valid cycle T in which the decimation count equals DECIMATE-1; the count
//     then wraps to 0. The trigger sample is x[n]. Tap j multiplies x[n-j] by coeff[j].
//     The computation base pointer is latched at T.
//   FSM: IDLE -> FETCH on a trigger.
//     FETCH lasts N_TAPS/2 cycles; k = 0..N_TAPS/2-1.
//     rom_en1 and rom_en2 are high, rom_addr1 = 2k, rom_addr2 = 2k+1.
//     The sample pair x[n-2k], x[n-2k-1] is registered in the same cycle.
//     FETCH -> DRAIN (3 cycles, pipeline flush) -> OUT (1 cycle) -> IDLE.
//   Pipeline per pair: issue -> ROM/sample align -> product register -> accumulate.
//     The accumulator is cleared on entry to FETCH.
//   Widths: product is IN_WIDTH+COEFF_WIDTH bits; accumulator is
//     IN_WIDTH+COEFF_WIDTH+clog2(N_TAPS) bits, full precision with no internal overflow.
//   Output: add 2**(OUT_SHIFT-1), arithmetic shift right by OUT_SHIFT (round half up),
//     then saturate to [-2**(OUT_WIDTH-1), 2**(OUT_WIDTH-1)-1].
//   Latency: dout_valid is high exactly at cycle T + N_TAPS/2 + 4, for one cycle.
//     dout holds its value until the next output.
//   busy is high from T+1 through T + N_TAPS/2 + 4; rom_en* are low outside FETCH.
//   Trigger while busy: the computation is not started, overrun pulses for one cycle, the
//     sample is still written, and the running computation completes unaffected.
//     A trigger in the OUT cycle is also dropped.
//   Rate contract: the producer spaces triggers at least N_TAPS/2+5 cycles apart.
// TESTING
//   Address/latency check (defaults): trigger at T -> rom_addr1 = 0,2,..,118 on T+1..T+60,
//     rom_addr2 = addr1+1, dout_valid only at T+64, busy low at T+65.
//   Impulse: coeff[j] = (j+1)*256; one sample of 100 as a trigger sample, then zeros every
//     4th cycle -> dout sequence 100, 2100, 4100, 6100, 8100, 10100, then 0.
//   DC: din = 100 constant, all coeffs 256, after the buffer has filled -> dout = 12000 on
//     every output.
//   Saturation: din = 2047 with coeffs 32767 -> dout = 32767;
//     din = -2048 with coeffs 32767 -> dout = -32768.
//   Overrun: din_valid every cycle (trigger every 20 cycles) -> overrun pulses at T+20,
//     T+40 and T+60; the first dout (T+64) is still correct.
//     The trigger at T+80 is accepted.
//   Reset mid-FETCH: rst_n low at T+30 -> all outputs 0 asynchronously and no dout_valid;
//     after release the impulse test passes again from a zeroed buffer.

Source files
------------

// File: rtl/fir_decimate.sv
// rtl/fir_decimate.sv - decimating FIR engine driving a dual-port coefficient ROM
//
// Purpose: keeps input samples in a circular buffer and, on every DECIMATE-th
// sample, runs an N_TAPS multiply-accumulate two taps per cycle (ROM port 1
// carries the even tap, port 2 the odd tap), then rounds, saturates and
// presents one output sample with a single-cycle valid pulse.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   din_valid, din        signed input sample stream
//   rom_en1/2, rom_addr1/2  coefficient ROM read requests (even / odd tap)
//   rom_do1/2             coefficient ROM data, one cycle after the request
//   dout_valid, dout      one-cycle output pulse and held signed output sample
//   busy                  a computation is in progress
//   overrun               one-cycle pulse when a trigger is dropped

module fir_decimate #(
  parameter int N_TAPS        = 120,
  parameter int DECIMATE      = 20,
  parameter int IN_WIDTH      = 12,
  parameter int COEFF_WIDTH   = 16,
  parameter int ADDRESS_WIDTH = 7,
  parameter int OUT_WIDTH     = 16,
  parameter int OUT_SHIFT     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     din_valid,
  input  logic [IN_WIDTH-1:0]      din,
  output logic                     rom_en1,
  output logic                     rom_en2,
  output logic [ADDRESS_WIDTH-1:0] rom_addr1,
  output logic [ADDRESS_WIDTH-1:0] rom_addr2,
  input  logic [COEFF_WIDTH-1:0]   rom_do1,
  input  logic [COEFF_WIDTH-1:0]   rom_do2,
  output logic                     dout_valid,
  output logic [OUT_WIDTH-1:0]     dout,
  output logic                     busy,
  output logic                     overrun
);

  localparam int DEPTH  = N_TAPS + DECIMATE;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int HALF   = N_TAPS / 2;
  localparam int K_W    = $clog2(HALF + 1);
  localparam int DCNT_W = $clog2(DECIMATE + 1);
  localparam int PROD_W = IN_WIDTH + COEFF_WIDTH;
  localparam int ACC_W  = PROD_W + $clog2(N_TAPS);
  localparam int RND_W  = ACC_W + 1;

  localparam logic [K_W-1:0]          K_LAST     = K_W'(HALF - 1);
  localparam logic [DCNT_W-1:0]       DCNT_LAST  = DCNT_W'(DECIMATE - 1);
  localparam logic [PTR_W-1:0]        PTR_LAST   = PTR_W'(DEPTH - 1);
  localparam logic [1:0]              DRAIN_LAST = 2'd2;
  localparam logic signed [RND_W-1:0] RND_ADD    = RND_W'(2 ** (OUT_SHIFT - 1));
  localparam logic signed [RND_W-1:0] SAT_MAX    = RND_W'(2 ** (OUT_WIDTH - 1) - 1);
  localparam logic signed [RND_W-1:0] SAT_MIN    = ~SAT_MAX;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_OUT} state_t;

  state_t                      state_q, state_d;
  logic [K_W-1:0]              k_q, k_d;
  logic [1:0]                  drain_q, drain_d;
  logic [PTR_W-1:0]            wp_q, rp_q;
  logic [DCNT_W-1:0]           dcnt_q;
  logic [IN_WIDTH-1:0]         buf_q [DEPTH];
  logic signed [IN_WIDTH-1:0]  samp_e_q, samp_o_q;
  logic                        v1_q, v2_q;
  logic signed [PROD_W-1:0]    prod_e_q, prod_o_q;
  logic signed [PROD_W-1:0]    prod_e_d, prod_o_d;
  logic signed [ACC_W-1:0]     acc_q;
  logic [OUT_WIDTH-1:0]        dout_q;

  logic                        trigger, start, fetch, load_dout;
  logic [PTR_W-1:0]            rp_odd, rp_step, wp_next;
  logic signed [RND_W-1:0]     rnd, shifted;
  logic [OUT_WIDTH-1:0]        sat;

  assign trigger   = din_valid && (dcnt_q == DCNT_LAST);
  assign start     = trigger && (state_q == S_IDLE);
  assign fetch     = (state_q == S_FETCH);
  assign load_dout = (state_q == S_DRAIN) && (drain_q == DRAIN_LAST);

  assign overrun    = trigger && (state_q != S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign dout_valid = (state_q == S_OUT);
  assign dout       = dout_q;
  assign rom_en1    = fetch;
  assign rom_en2    = fetch;
  assign rom_addr1  = fetch ? ADDRESS_WIDTH'({k_q, 1'b0}) : '0;
  assign rom_addr2  = fetch ? ADDRESS_WIDTH'({k_q, 1'b1}) : '0;

  // Read pointer walks backwards in time, two samples per FETCH cycle.
  assign rp_odd  = (rp_q == '0) ? PTR_LAST : rp_q - PTR_W'(1);
  assign rp_step = (rp_q < PTR_W'(2)) ? rp_q + PTR_W'(DEPTH - 2) : rp_q - PTR_W'(2);
  assign wp_next = (wp_q == PTR_LAST) ? '0 : wp_q + PTR_W'(1);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    drain_d = drain_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          k_d     = '0;
        end
      end
      S_FETCH: begin
        k_d = k_q + K_W'(1);
        if (k_q == K_LAST) begin
          state_d = S_DRAIN;
          k_d     = '0;
          drain_d = '0;
        end
      end
      S_DRAIN: begin
        drain_d = drain_q + 2'd1;
        if (drain_q == DRAIN_LAST) state_d = S_OUT;
      end
      S_OUT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operands are widened to the product width so the multiply is full precision.
  always_comb begin
    prod_e_d = PROD_W'(samp_e_q) * PROD_W'($signed(rom_do1));
    prod_o_d = PROD_W'(samp_o_q) * PROD_W'($signed(rom_do2));
  end

  // Round half up, then clamp to the output range.
  always_comb begin
    rnd     = RND_W'(acc_q) + RND_ADD;
    shifted = rnd >>> OUT_SHIFT;
    if (shifted > SAT_MAX)      sat = SAT_MAX[OUT_WIDTH-1:0];
    else if (shifted < SAT_MIN) sat = SAT_MIN[OUT_WIDTH-1:0];
    else                        sat = shifted[OUT_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
    end else if (din_valid) begin
      buf_q[wp_q] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      drain_q  <= '0;
      wp_q     <= '0;
      rp_q     <= '0;
      dcnt_q   <= '0;
      samp_e_q <= '0;
      samp_o_q <= '0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      prod_e_q <= '0;
      prod_o_q <= '0;
      acc_q    <= '0;
      dout_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      drain_q <= drain_d;
      if (din_valid) begin
        wp_q   <= wp_next;
        dcnt_q <= trigger ? '0 : dcnt_q + DCNT_W'(1);
      end
      // The trigger sample lands at wp_q this cycle and becomes tap 0.
      if (start) rp_q <= wp_q;
      else if (fetch) rp_q <= rp_step;
      if (fetch) begin
        samp_e_q <= buf_q[rp_q];
        samp_o_q <= buf_q[rp_odd];
      end
      v1_q <= fetch;
      v2_q <= v1_q;
      if (v1_q) begin
        prod_e_q <= prod_e_d;
        prod_o_q <= prod_o_d;
      end
      if (start) acc_q <= '0;
      else if (v2_q) acc_q <= acc_q + ACC_W'(prod_e_q) + ACC_W'(prod_o_q);
      if (load_dout) dout_q <= sat;
    end
  end

endmodule
